// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a single-port 32-bit word memory (req/resp valid-ready in, mem_we/mem_addr/mem_wdata/mem_rdata out), byte stores via read-modify-write
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0] lane_q;
  logic we_q, size_q, signed_q;
  logic [7:0] byte_q, rd_byte;
  logic err, accept;
  logic [31:0] merged, ld_data;
  assign err = ((req_addr >> (ADDR_WIDTH + 2)) != 32'h0) || (req_size && req_addr[1:0] != 2'b00);
  assign req_ready = !rst && state == IDLE;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_data = size_q ? mem_rdata : signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
  always_comb begin
    merged = mem_rdata;
    merged[{lane_q, 3'b000} +: 8] = byte_q;
  end
  assign mem_addr = state == IDLE ? req_addr[ADDR_WIDTH+1:2] : addr_q;
  assign mem_we = !rst && (state == IDLE ? accept && req_we && req_size && !err : state == RD && we_q);
  assign mem_wdata = state == RD ? merged : req_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      addr_q <= '0;
      lane_q <= '0;
      we_q <= 1'b0;
      size_q <= 1'b0;
      signed_q <= 1'b0;
      byte_q <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        addr_q <= req_addr[ADDR_WIDTH+1:2];
        lane_q <= req_addr[1:0];
        we_q <= req_we;
        size_q <= req_size;
        signed_q <= req_signed;
        byte_q <= req_wdata[7:0];
        resp_rdata <= '0;
        resp_err <= err;
        state <= (err || (req_we && req_size)) ? RESP : RD;
      end
    end else if (state == RD) begin
      resp_rdata <= we_q ? 32'h0 : ld_data;
      state <= RESP;
    end else if (resp_ready)
      state <= IDLE;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a queue scoreboard and independent response monitor
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0, req_size = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic resp_valid, resp_ready = 1'b1, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata = '0;
  logic [9:0] mem_addr;
  logic [31:0] mem [0:1023];
  int checks = 0, errors = 0, cyc = 0, we_cnt = 0;
  typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } exp_t;
  exp_t q[$];
  exp_t e;
  mem_access_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && resp_valid) begin
      chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
      chk("mem_we_in_resp", {31'h0, mem_we}, 32'h0);
      if (resp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h err %b expected no response", resp_rdata, resp_err);
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          chk("latency", cyc - e.acc, e.lat);
        end
      end
    end
  task automatic send(input logic we, input logic size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] wdata, output int acc);
    @(negedge clk);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic push(input logic [31:0] rdata, input logic err, input int acc, input int lat);
    exp_t x;
    x.rdata = rdata;
    x.err = err;
    x.acc = acc;
    x.lat = lat;
    q.push_back(x);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response expected %0d pending", q.size());
      q.delete();
    end
  endtask
  task automatic xact(input logic we, input logic size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err, input int lat);
    int acc;
    send(we, size, sgn, addr, wdata, acc);
    push(rdata, err, acc, lat);
    wait_done();
  endtask
  initial begin
    int acc, w0;
    logic [31:0] held;
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, w0;
    logic [31:0] held;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 1'b1;
    #2;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    xact(1, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    xact(0, 1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    xact(1, 1, 0, 32'h10, 32'h11223344, 32'h0, 0, 1);
    send(1, 0, 0, 32'h13, 32'h000000A5, acc);
    push(32'h0, 0, acc, 2);
    @(negedge clk);
    chk("rmw_mem_we", {31'h0, mem_we}, 32'h1);
    chk("rmw_mem_wdata", mem_wdata, 32'hA5223344);
    chk("rmw_mem_addr", {22'h0, mem_addr}, 32'h4);
    wait_done();
    xact(0, 1, 0, 32'h10, 32'h0, 32'hA5223344, 0, 2);
    xact(0, 0, 1, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 2);
    xact(0, 0, 0, 32'h13, 32'h0, 32'h000000A5, 0, 2);
    xact(0, 0, 1, 32'h10, 32'h0, 32'h00000044, 0, 2);
    xact(0, 0, 1, 32'h11, 32'h0, 32'h00000033, 0, 2);
    w0 = we_cnt;
    xact(0, 1, 0, 32'h6, 32'h0, 32'h0, 1, 1);
    xact(1, 1, 0, 32'h6, 32'hCAFEF00D, 32'h0, 1, 1);
    xact(0, 0, 0, 32'h1000, 32'h0, 32'h0, 1, 1);
    xact(1, 0, 0, 32'h1000, 32'h000000FF, 32'h0, 1, 1);
    xact(1, 1, 0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 1);
    chk("err_no_write", we_cnt, w0);
    xact(0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 2);
    xact(1, 1, 0, 32'hFFC, 32'h12345678, 32'h0, 0, 1);
    xact(1, 0, 0, 32'hFFF, 32'h0000009C, 32'h0, 0, 2);
    xact(0, 1, 0, 32'hFFC, 32'h0, 32'h9C345678, 0, 2);
    xact(0, 0, 1, 32'hFFF, 32'h0, 32'hFFFFFF9C, 0, 2);
    resp_ready = 1'b0;
    send(0, 1, 0, 32'h10, 32'h0, acc);
    push(32'hA5223344, 0, acc, 8);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("bp_first_latency", cyc - acc, 2);
    held = resp_rdata;
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'h0, resp_valid}, 32'h1);
      chk("bp_rdata_hold", resp_rdata, held);
    end
    chk("bp_no_write", we_cnt, w0);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_done();
    xact(1, 1, 0, 32'h20, 32'h55667788, 32'h0, 0, 1);
    xact(0, 1, 0, 32'h20, 32'h0, 32'h55667788, 0, 2);
    w0 = we_cnt;
    send(1, 0, 0, 32'h21, 32'h000000FF, acc);
    rst = 1'b1;
    #1;
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_resp_rdata", resp_rdata, 32'h0);
    chk("mid_rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("mid_rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("mid_rst_mem_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1 chk("mid_rst_mem_we_edge", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_no_write", we_cnt, w0);
    xact(0, 1, 0, 32'h20, 32'h0, 32'h55667788, 0, 2);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the core's single-port block memory. Accepts load/store requests from the core pipeline over a valid/ready handshake, drives the memory's write-enable, word address and write data, captures read data one cycle after the address is presented, and returns a response over a second valid/ready handshake. Supports word and byte accesses. Byte stores use read-modify-write, since the memory has no byte enables.

## Interface
- ADDR_WIDTH, 10, memory word-address width; memory holds 2^ADDR_WIDTH 32-bit words (4096 bytes at default).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid&&req_ready.
- req_we  in  1  1=store, 0=load.
- req_size  in  1  0=byte, 1=word.
- req_signed  in  1  byte load: 1=sign-extend, 0=zero-extend; ignored otherwise.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte store uses bits [7:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid&&resp_ready.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request was misaligned or out of range.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid one cycle after mem_addr is presented.

## Operation
- Memory contract: a write happens at the rising edge where mem_we=1. mem_rdata reflects the word addressed in the previous cycle.
- Word index: req_addr[ADDR_WIDTH+1:2]. Byte lane: req_addr[1:0], little-endian; lane k occupies bits [8k+7:8k].
- Error cases:
  - Word access with req_addr[1:0]!=0.
  - Any access with req_addr >= 4*2^ADDR_WIDTH.
  - An errored request never asserts mem_we. It goes straight to RESP with resp_err=1 and resp_rdata=0.
- State machine states: IDLE, RD, RESP.
- IDLE:
  - req_ready=1.
  - mem_addr driven combinationally from req_addr.
  - mem_we = req_valid & req_we & word & no-error; mem_wdata = req_wdata.
  - On accept, latch addr, lane, we, size, signed and wdata[7:0].
  - Next state: error or word store -> RESP; load or byte store -> RD.
- RD:
  - mem_addr from the latched address.
  - Load: capture the result into resp_rdata. Word -> mem_rdata. Byte -> the selected lane, extended per req_signed. Go to RESP.
  - Byte store: mem_we=1; mem_wdata = mem_rdata with the selected lane replaced by the latched byte. Go to RESP.
- RESP:
  - resp_valid=1; req_ready=0; mem_we=0.
  - resp_rdata and resp_err held stable until resp_ready.
  - On handshake -> IDLE.
- Outside these cases mem_we=0, and mem_wdata is don't-care.
- Only one request is in flight; a new request is accepted only after the previous response handshake.

## Timing
- Reset values (async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, all latched fields 0.
- While rst=1: req_ready=0 and mem_we=0, forced combinationally.
- Latency, for accept at cycle N with resp_ready=1:
  - Word store or error: resp_valid in cycle N+1; memory written at end of cycle N.
  - Load: resp_valid in cycle N+2.
  - Byte store: write at end of cycle N+1; resp_valid in cycle N+2.
- Minimum request spacing is 2 cycles (word store/error) or 3 cycles (load/byte store). No request is accepted in the same cycle as a response handshake.
- Backpressure: resp_ready low holds RESP indefinitely. No memory activity occurs and req_ready stays 0.
- Reset asserted mid-operation (RD or RESP): the pending byte-store write is dropped, the response is discarded, and the block returns to IDLE.
- req_addr exactly 4*2^ADDR_WIDTH-1 is in range for a byte access. 4*2^ADDR_WIDTH-4 is the last valid word address.

## Test plan
- Word store then load at addr 0x10, data 0xDEADBEEF:
  - Store resp_valid at N+1, resp_err=0.
  - Load resp_rdata=0xDEADBEEF at accept+2.
- Byte store 0xA5 to 0x13 over word 0x11223344:
  - mem_we in cycle N+1 with mem_wdata=0xA5223344.
  - Word load returns 0xA5223344.
- Byte load from 0x13 holding 0xA5:
  - req_signed=1 -> 0xFFFFFFA5.
  - req_signed=0 -> 0x000000A5.
- Word load at 0x6, and any access at 0x1000 (ADDR_WIDTH=10):
  - resp_err=1, resp_rdata=0, at N+1.
  - mem_we never asserted.
- Backpressure: hold resp_ready=0 for 5 cycles after a load response.
  - resp_valid/rdata stay stable; req_ready=0; mem_we=0.
  - Handshake returns the block to IDLE.
- Assert rst during RD of a byte store.
  - No write occurs (word unchanged on readback).
  - All outputs reach reset values immediately; req_ready=1 after release.
